// File: rtl/artemis_ddr3_port_ctrl.sv
// Request engine for one bidirectional Artemis DDR3 user port: turns burst
// read/write requests into MCB command, write-FIFO and read-FIFO traffic.
module artemis_ddr3_port_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        calibration_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [27:0] req_addr,
  input  logic [5:0]  req_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        error,
  output logic        mcb_cmd_en,
  output logic [2:0]  mcb_cmd_instr,
  output logic [5:0]  mcb_cmd_bl,
  output logic [29:0] mcb_cmd_byte_addr,
  input  logic        mcb_cmd_full,
  output logic        mcb_wr_en,
  output logic [3:0]  mcb_wr_mask,
  output logic [31:0] mcb_wr_data,
  input  logic        mcb_wr_full,
  input  logic        mcb_wr_empty,
  input  logic        mcb_wr_underrun,
  input  logic        mcb_wr_error,
  output logic        mcb_rd_en,
  input  logic [31:0] mcb_rd_data,
  input  logic        mcb_rd_empty,
  input  logic        mcb_rd_overflow,
  input  logic        mcb_rd_error
);

  // state    | meaning
  // FLUSH    | drain stale read data, wait for empty FIFOs and calibration
  // IDLE     | accept a request
  // WR_FILL  | stream len+1 words into the write FIFO
  // WR_CMD   | issue the write command
  // RD_CMD   | issue the read command
  // RD_DRAIN | pop len+1 words from the read FIFO
  typedef enum logic [2:0] {
    FLUSH    = 3'd0,
    IDLE     = 3'd1,
    WR_FILL  = 3'd2,
    WR_CMD   = 3'd3,
    RD_CMD   = 3'd4,
    RD_DRAIN = 3'd5
  } state_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  state_t      state_q, state_d;
  logic [27:0] addr_q, addr_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        accept;
  logic        fault;

  assign fault = mcb_wr_underrun | mcb_wr_error | mcb_rd_overflow | mcb_rd_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FLUSH;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    error_d       = error_q;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    accept        = 1'b0;
    req_ready     = 1'b0;
    wr_ready      = 1'b0;
    mcb_wr_en     = 1'b0;
    mcb_wr_data   = '0;
    mcb_cmd_en    = 1'b0;
    mcb_cmd_instr = CMD_WR;
    mcb_rd_en     = 1'b0;

    case (state_q)
      FLUSH: begin
        mcb_rd_en = !mcb_rd_empty;
        if (mcb_rd_empty && mcb_wr_empty && calibration_done) state_d = IDLE;
      end
      IDLE: begin
        req_ready = calibration_done;
        if (req_valid && calibration_done) begin
          accept  = 1'b1;
          addr_d  = req_addr;
          len_d   = req_len;
          cnt_d   = '0;
          state_d = req_write ? WR_FILL : RD_CMD;
        end
      end
      WR_FILL: begin
        wr_ready    = !mcb_wr_full;
        mcb_wr_data = wr_data;
        mcb_wr_en   = wr_valid && !mcb_wr_full;
        if (mcb_wr_en) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == len_q) state_d = WR_CMD;
        end
      end
      WR_CMD: begin
        mcb_cmd_en    = !mcb_cmd_full;
        mcb_cmd_instr = CMD_WR;
        if (mcb_cmd_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      RD_CMD: begin
        mcb_cmd_en    = !mcb_cmd_full;
        mcb_cmd_instr = CMD_RD;
        if (mcb_cmd_en) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        // Leaving on the final pop keeps the pop count bounded at len+1.
        mcb_rd_en = !mcb_rd_empty;
        if (mcb_rd_en) begin
          cnt_d      = cnt_q + 6'd1;
          rd_valid_d = 1'b1;
          rd_data_d  = mcb_rd_data;
          if (cnt_q == len_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = FLUSH;
    endcase

    // A fault in the accept cycle belongs to the new request.
    if (accept) error_d = 1'b0;
    if (fault)  error_d = 1'b1;

    if (rst) begin
      req_ready     = 1'b0;
      wr_ready      = 1'b0;
      mcb_wr_en     = 1'b0;
      mcb_wr_data   = '0;
      mcb_cmd_en    = 1'b0;
      mcb_cmd_instr = CMD_WR;
      mcb_rd_en     = 1'b0;
    end
  end

  assign mcb_cmd_bl        = len_q;
  assign mcb_cmd_byte_addr = {addr_q, 2'b00};
  assign mcb_wr_mask       = 4'b0000;
  assign done              = done_q;
  assign error             = error_q;
  assign rd_valid          = rd_valid_q;
  assign rd_data           = rd_data_q;

endmodule

// File: tb/tb_artemis_ddr3_port_ctrl.sv
// Randomized bench for artemis_ddr3_port_ctrl against a queue-based MCB model
// and per-request expectations derived from the request itself.
module tb_artemis_ddr3_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        calibration_done;
  logic        req_valid, req_ready, req_write;
  logic [27:0] req_addr;
  logic [5:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, error;
  logic        mcb_cmd_en;
  logic [2:0]  mcb_cmd_instr;
  logic [5:0]  mcb_cmd_bl;
  logic [29:0] mcb_cmd_byte_addr;
  logic        mcb_cmd_full;
  logic        mcb_wr_en;
  logic [3:0]  mcb_wr_mask;
  logic [31:0] mcb_wr_data;
  logic        mcb_wr_full, mcb_wr_empty, mcb_wr_underrun, mcb_wr_error;
  logic        mcb_rd_en;
  logic [31:0] mcb_rd_data;
  logic        mcb_rd_empty, mcb_rd_overflow, mcb_rd_error;

  always #5 clk = ~clk;

  artemis_ddr3_port_ctrl dut (
    .clk(clk), .rst(rst), .calibration_done(calibration_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .error(error),
    .mcb_cmd_en(mcb_cmd_en), .mcb_cmd_instr(mcb_cmd_instr), .mcb_cmd_bl(mcb_cmd_bl),
    .mcb_cmd_byte_addr(mcb_cmd_byte_addr), .mcb_cmd_full(mcb_cmd_full),
    .mcb_wr_en(mcb_wr_en), .mcb_wr_mask(mcb_wr_mask), .mcb_wr_data(mcb_wr_data),
    .mcb_wr_full(mcb_wr_full), .mcb_wr_empty(mcb_wr_empty),
    .mcb_wr_underrun(mcb_wr_underrun), .mcb_wr_error(mcb_wr_error),
    .mcb_rd_en(mcb_rd_en), .mcb_rd_data(mcb_rd_data), .mcb_rd_empty(mcb_rd_empty),
    .mcb_rd_overflow(mcb_rd_overflow), .mcb_rd_error(mcb_rd_error)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [31:0] rdq[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_words[$];
  logic [31:0] exp_wr[$];
  logic [31:0] got_wr[$];
  int wr_fifo_cnt = 0;
  bit wr_drain = 1'b1;
  bit rd_gap_en, wr_full_rand, wr_valid_rand;
  int cmd_full_left = 0;
  int ovf_at_word = -1;
  logic [31:0] rd_pat_base = '0;
  bit req_pend = 1'b0;
  bit cur_write, in_flush;

  int acc_cyc, cmd_cnt, done_cnt, done_cyc, cmd_cyc, rd_cnt, flush_pops;
  logic [2:0]  cmd_instr_s;
  logic [5:0]  cmd_bl_s;
  logic [29:0] cmd_addr_s;
  bit rdy_at_done, err_at_done, err_at_acc, rdy_seen;
  int err_after_acc;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock: drive inputs at the falling edge, observe what the DUT will
  // commit at the next rising edge, then advance the MCB/driver model.
  task automatic step();
    bit gap;
    @(negedge clk);
    cyc++;
    gap             = rd_gap_en && ($urandom_range(0, 1) == 0);
    mcb_rd_empty    = (rdq.size() == 0) || gap;
    mcb_rd_data     = (rdq.size() != 0) ? rdq[0] : $urandom;
    mcb_wr_full     = (wr_fifo_cnt >= 64) || (wr_full_rand && $urandom_range(0, 1) == 0);
    mcb_wr_empty    = (wr_fifo_cnt == 0);
    mcb_cmd_full    = (cmd_full_left > 0);
    mcb_rd_overflow = (ovf_at_word >= 0) && (rd_cnt == ovf_at_word);
    req_valid       = req_pend;
    wr_valid        = (wr_words.size() != 0) && (!wr_valid_rand || $urandom_range(0, 1) == 1);
    wr_data         = (wr_words.size() != 0) ? wr_words[0] : $urandom;
    #1;
    if (req_ready) rdy_seen = 1'b1;
    if (rd_valid) begin
      rd_cnt++;
      if (exp_rd.size() == 0) chk_eq("rd_extra_word", rd_valid, 0);
      else chk_eq("rd_data", rd_data, exp_rd.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      rdy_at_done = req_ready;
      err_at_done = error;
      if (!cur_write) chk_eq("done_on_last_rd", {rd_valid, exp_rd.size() == 0}, 2'b11);
    end
    if (cyc == acc_cyc + 1) err_after_acc = int'(error);
    if (req_valid && req_ready) begin
      acc_cyc    = cyc;
      err_at_acc = error;
      req_pend   = 1'b0;
    end
    if (wr_valid && wr_ready) void'(wr_words.pop_front());
    if (mcb_wr_en) begin
      chk_eq("wr_en_while_full", mcb_wr_full, 0);
      got_wr.push_back(mcb_wr_data);
      wr_fifo_cnt++;
    end
    if (mcb_rd_en) begin
      chk_eq("rd_en_while_empty", mcb_rd_empty, 0);
      if (rdq.size() != 0) void'(rdq.pop_front());
      if (in_flush) flush_pops++;
    end
    if (mcb_cmd_en) begin
      chk_eq("cmd_en_while_full", mcb_cmd_full, 0);
      cmd_cnt++;
      cmd_cyc     = cyc;
      cmd_instr_s = mcb_cmd_instr;
      cmd_bl_s    = mcb_cmd_bl;
      cmd_addr_s  = mcb_cmd_byte_addr;
      if (mcb_cmd_instr == 3'b001) begin
        for (int i = 0; i <= int'(mcb_cmd_bl); i++) begin
          logic [31:0] w;
          w = (rd_pat_base != 0) ? rd_pat_base + i : $urandom;
          rdq.push_back(w);
          exp_rd.push_back(w);
        end
      end
    end
    if (mcb_rd_overflow) ovf_at_word = -1;
    if (cmd_full_left > 0 && wr_words.size() == 0) cmd_full_left--;
    if (wr_drain && wr_fifo_cnt > 0) wr_fifo_cnt--;
  endtask

  task automatic clear_records();
    cmd_cnt = 0; done_cnt = 0; rd_cnt = 0; flush_pops = 0;
    acc_cyc = -100; cmd_cyc = -1; done_cyc = -1; err_after_acc = -1;
    got_wr.delete(); exp_rd.delete();
  endtask

  task automatic run_req(input bit wr, input logic [27:0] addr, input logic [5:0] len,
                         input bit stall, input int ovf_word, input logic [31:0] pat);
    clear_records();
    cur_write = wr;
    exp_wr.delete();
    wr_words.delete();
    if (wr) begin
      for (int i = 0; i <= int'(len); i++) begin
        logic [31:0] w;
        w = (pat != 0) ? pat + i : $urandom;
        wr_words.push_back(w);
        exp_wr.push_back(w);
      end
    end
    rd_pat_base   = wr ? 32'h0 : pat;
    wr_full_rand  = stall;
    wr_valid_rand = stall;
    rd_gap_en     = stall;
    cmd_full_left = stall ? 5 : 0;
    ovf_at_word   = ovf_word;
    req_write     = wr;
    req_addr      = addr;
    req_len       = len;
    req_pend      = 1'b1;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
    repeat (4) step();
    chk_eq("done_count", done_cnt, 1);
    chk_eq("cmd_count", cmd_cnt, 1);
    chk_eq("cmd_instr", cmd_instr_s, wr ? 3'b000 : 3'b001);
    chk_eq("cmd_bl", cmd_bl_s, len);
    chk_eq("cmd_byte_addr", cmd_addr_s, {addr, 2'b00});
    chk_eq("cmd_before_done", cmd_cyc < done_cyc, 1);
    chk_eq("ready_at_done", rdy_at_done, 1);
    chk_eq("err_at_done", err_at_done, ovf_word >= 0);
    if (wr) begin
      chk_eq("wr_count", got_wr.size(), int'(len) + 1);
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
        chk_eq("wr_data", got_wr[i], exp_wr[i]);
    end else begin
      chk_eq("rd_count", rd_cnt, int'(len) + 1);
    end
    if (!stall) begin
      chk_eq("cmd_latency", cmd_cyc - acc_cyc, wr ? int'(len) + 2 : 1);
      chk_eq("done_latency", done_cyc - acc_cyc, int'(len) + 3);
    end
    wr_full_rand = 0; wr_valid_rand = 0; rd_gap_en = 0; cmd_full_left = 0; ovf_at_word = -1;
  endtask

  initial begin
    rst = 1'b1; calibration_done = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
    wr_valid = 0; wr_data = '0;
    mcb_cmd_full = 0; mcb_wr_full = 0; mcb_wr_empty = 1; mcb_wr_underrun = 0;
    mcb_wr_error = 0; mcb_rd_data = '0; mcb_rd_empty = 1; mcb_rd_overflow = 0; mcb_rd_error = 0;
    clear_records();
    cur_write = 1'b1;

    // Reset with stale read data: three discarded pops, then ready.
    rdq.push_back(32'h111); rdq.push_back(32'h222); rdq.push_back(32'h333);
    in_flush = 1'b1;
    repeat (3) step();
    chk_eq("reset_outputs", {req_ready, wr_ready, rd_valid, done, error, mcb_cmd_en, mcb_wr_en, mcb_rd_en}, 8'h00);
    rst = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 20 && !rdy_seen; i++) step();
    chk_eq("flush_pops", flush_pops, 3);
    chk_eq("flush_rd_valid", rd_cnt, 0);
    chk_eq("flush_ready", rdy_seen, 1);
    in_flush = 1'b0;

    calibration_done = 1'b0;
    step();
    chk_eq("ready_no_calib", req_ready, 0);
    calibration_done = 1'b1;
    step();
    chk_eq("ready_calib", req_ready, 1);

    run_req(1'b1, 28'h0000010, 6'd3, 1'b0, -1, 32'hA0);
    run_req(1'b0, 28'h0000010, 6'd3, 1'b0, -1, 32'hA0);
    run_req(1'b1, 28'h0ABCDEF, 6'd63, 1'b1, -1, 32'h0);
    run_req(1'b0, 28'hFFFFFC0, 6'd63, 1'b1, -1, 32'h0);
    run_req(1'b0, 28'h0000100, 6'd0, 1'b0, -1, 32'h0);

    // Overflow mid-read: error sticks until the next request is accepted.
    run_req(1'b0, 28'h0000200, 6'd7, 1'b0, 3, 32'h0);
    run_req(1'b1, 28'h0000300, 6'd1, 1'b0, -1, 32'h0);
    chk_eq("err_held_to_accept", err_at_acc, 1);
    chk_eq("err_cleared_after_accept", err_after_acc, 0);

    for (int t = 0; t < 16; t++)
      run_req($urandom_range(0, 1) == 1, 28'($urandom), 6'($urandom_range(0, 63)),
              $urandom_range(0, 1) == 1, -1, 32'h0);

    // Reset after two of eight write words; residual write data blocks FLUSH.
    clear_records();
    cur_write = 1'b1;
    wr_drain  = 1'b0;
    wr_words.delete();
    for (int i = 0; i < 8; i++) wr_words.push_back($urandom);
    req_write = 1'b1; req_addr = 28'h0000400; req_len = 6'd7; req_pend = 1'b1;
    for (int i = 0; i < 100 && got_wr.size() < 2; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_words.delete();
    req_pend = 1'b0;
    rdy_seen = 1'b0;
    repeat (15) step();
    chk_eq("midrst_cmd", cmd_cnt, 0);
    chk_eq("midrst_done", done_cnt, 0);
    chk_eq("midrst_words", got_wr.size(), 2);
    chk_eq("midrst_held_in_flush", rdy_seen, 0);
    wr_drain = 1'b1;
    for (int i = 0; i < 50 && !rdy_seen; i++) step();
    chk_eq("midrst_ready_after_empty", rdy_seen, 1);

    run_req(1'b1, 28'h0000500, 6'd5, 1'b0, -1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/artemis_ddr3_port_ctrl.md
# artemis_ddr3_port_ctrl

Single-port request engine that sits directly upstream of one bidirectional DDR3 user port (p0 or p1) of the Artemis infrastructure. It turns word-addressed burst read/write requests plus a streaming data interface into the MCB command, write-FIFO and read-FIFO sequence, and owns that port's FIFO handshakes. Nysa memory and host adapters instantiate one copy per bidirectional port. All MCB port clocks (cmd/wr/rd) are driven from `clk` at the top level.

## Interface
- No parameters. Data width is fixed at 32 bits; burst length is at most 64 words.

- `clk` in 1: system clock; the port's cmd/wr/rd clocks are tied to it.
- `rst` in 1: reset, synchronous and active-high.
- `calibration_done` in 1: DDR3 calibration complete.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 28: 32-bit word address.
- `req_len` in 6: burst length minus 1 (0 = 1 word, 63 = 64 words).
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in 32: write stream.
- `rd_valid` out 1, `rd_data` out 32: read stream. There is no backpressure; the sink must accept every word.
- `done` out 1: one-cycle pulse when a request completes.
- `error` out 1: sticky MCB fault flag.
- `mcb_cmd_en` out 1, `mcb_cmd_instr` out 3, `mcb_cmd_bl` out 6, `mcb_cmd_byte_addr` out 30, `mcb_cmd_full` in 1.
- `mcb_wr_en` out 1, `mcb_wr_mask` out 4, `mcb_wr_data` out 32, `mcb_wr_full` in 1, `mcb_wr_empty` in 1, `mcb_wr_underrun` in 1, `mcb_wr_error` in 1.
- `mcb_rd_en` out 1, `mcb_rd_data` in 32, `mcb_rd_empty` in 1, `mcb_rd_overflow` in 1, `mcb_rd_error` in 1.

## Operation
- States: FLUSH, IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN.
- `rst` → FLUSH. All outputs go to 0 except `req_ready`, which is also 0. The word counter and the latched address/length are cleared.
- FLUSH
  - `mcb_rd_en` = !`mcb_rd_empty`; popped data is discarded and `rd_valid` stays 0.
  - Exit to IDLE once `mcb_rd_empty` && `mcb_wr_empty` && `calibration_done`.
- IDLE
  - `req_ready` = `calibration_done`.
  - On accept: latch `req_addr`, `req_len` and `req_write`; clear `error` and the counter.
  - Go to WR_FILL if `req_write`, else RD_CMD.
- WR_FILL
  - `wr_ready` = !`mcb_wr_full`.
  - `mcb_wr_en` = `wr_valid` && `wr_ready`; `mcb_wr_data` = `wr_data` (combinational); `mcb_wr_mask` = 4'b0000.
  - Counter increments on each transfer. On the transfer where counter == len, go to WR_CMD.
- WR_CMD
  - `mcb_cmd_en` = !`mcb_cmd_full`, with `mcb_cmd_instr` = 3'b000.
  - On the cycle `cmd_en` is asserted, go to IDLE and pulse `done` on the next cycle.
- RD_CMD
  - `mcb_cmd_en` = !`mcb_cmd_full`, with `mcb_cmd_instr` = 3'b001.
  - On the cycle `cmd_en` is asserted, go to RD_DRAIN.
- RD_DRAIN
  - `mcb_rd_en` = !`mcb_rd_empty` while popped < len+1.
  - Each pop yields `rd_data` ← `mcb_rd_data` and `rd_valid` = 1, both registered, on the next cycle.
  - `done` pulses coincident with the final `rd_valid`; the state then returns to IDLE.
- Command fields, valid whenever `mcb_cmd_en` = 1:
  - `mcb_cmd_bl` = latched len.
  - `mcb_cmd_byte_addr` = {latched addr, 2'b00}.
  - Address wrap at 2^28 words is the MCB's responsibility; this block adds no boundary check.
- `error` is set when any of `mcb_wr_underrun`, `mcb_wr_error`, `mcb_rd_overflow` or `mcb_rd_error` is high in any state. It holds until the next request is accepted or `rst`. The FSM continues normally after setting it.
- Reset mid-operation:
  - Return to FLUSH immediately and discard the latched request; no `done` pulse.
  - Residual read data is drained. Residual write data is left in place; FLUSH waits for `mcb_wr_empty`.

## Timing
- Request accept happens on cycle N; the first cycle of WR_FILL or RD_CMD is N+1.
- Write of L words with no stalls:
  - Data transfers in cycles N+1..N+L.
  - `mcb_cmd_en` at N+L+1.
  - `done` at N+L+2.
  - `req_ready` is high again at N+L+2.
- Read:
  - `mcb_cmd_en` at N+1 if `mcb_cmd_full` = 0.
  - `rd_valid` lags each `mcb_rd_en` by exactly 1 cycle.
  - `done` coincides with the last `rd_valid`.
- A stall on `mcb_cmd_full`, `mcb_wr_full` or `mcb_rd_empty` holds the state with no lost or duplicated words.
- `req_ready` is 0 in every state other than IDLE; back-to-back requests are therefore spaced by at least one IDLE cycle.
- `calibration_done` dropping while in IDLE deasserts `req_ready` the same cycle. Dropping during a transfer has no effect on the transfer in progress.

## Test plan
- **Reset/flush:** preload the MCB model's read FIFO with 3 words, pulse `rst`, hold `calibration_done` = 1 → three `mcb_rd_en` cycles with `rd_valid` = 0, then `req_ready` = 1.
- **Write:** addr 0x0000010, len 3 (4 words) with data 0xA0..0xA3 → four `mcb_wr_en` cycles carrying that data, then a single `mcb_cmd_en` with instr 000, bl 3, byte_addr 0x40, then a `done` pulse.
- **Read:** addr 0x0000010, len 3 with the model returning 0xA0..0xA3 → `cmd_en` with instr 001, bl 3, then 4 `rd_valid` words in order, with `done` on the 4th.
- **Stalls:** `mcb_cmd_full` high for 5 cycles, `mcb_wr_full` toggling, and `mcb_rd_empty` gaps during 64-word bursts (len 63) → exact word counts, no duplicates, bl = 63.
- **Error:** pulse `mcb_rd_overflow` mid-read → `error` = 1 until the next accept, and the read still completes with `done`.
- **Reset mid-write:** assert `rst` after 2 of 8 words → no `cmd_en` and no `done`, and the block returns to FLUSH.
